// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings, FSM states,
// access legality, alignment, and store lane steering.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

    // funct3[1:0] encodes the access size for both loads and stores
    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        case (f3[1:0])
            2'b01:   ok = ~lo[0];
            2'b10:   ok = (lo == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] s;
        case (f3[1:0])
            2'b00:   s = 4'b0001 << lo;
            2'b01:   s = 4'b0011 << {lo[1], 1'b0};
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Selects the addressed byte/halfword lane of a bus word and sign- or zero-extends it.
// Purely combinational.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] rdata
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = mem_rdata[{addr, 3'b000} +: 8];
        h = mem_rdata[{addr[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    rdata = {{24{b[7]}}, b};
            F3_H:    rdata = {{16{h[15]}}, h};
            F3_BU:   rdata = {24'd0, b};
            F3_HU:   rdata = {16'd0, h};
            default: rdata = mem_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store stage: one bus transaction per req_valid, stalling the core until done.
// Store min latency 3 cycles, load 4; bus backpressure via mem_gnt/mem_rvalid, bounded by timeout.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES);

    state_t      state;
    logic [2:0]  lat_f3;
    logic [1:0]  lat_lo;
    logic [31:0] cnt;
    logic [31:0] ext_rdata;
    logic        timeout_hit;

    lsu_load_extend u_ext (
        .funct3    (lat_f3),
        .addr      (lat_lo),
        .mem_rdata (mem_rdata),
        .rdata     (ext_rdata)
    );

    // cnt holds the number of REQ/WAIT cycles already completed, so this fires on the last allowed one
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((cnt + 32'd1) >= TO_LIM);
    assign stall       = req_valid & ~done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wstrb <= 4'd0;
            mem_wdata <= 32'd0;
            lat_f3    <= 3'd0;
            lat_lo    <= 2'd0;
            cnt       <= 32'd0;
        end else begin
            done <= 1'b0;
            if (state == REQ || state == WAIT) cnt <= cnt + 32'd1;
            case (state)
                IDLE: if (req_valid) begin
                    if (!is_legal(req_we, funct3) || !is_aligned(funct3, addr[1:0])) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                        rdata <= 32'd0;
                    end else begin
                        state     <= REQ;
                        mem_req   <= 1'b1;
                        mem_we    <= req_we;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_wstrb <= req_we ? store_strb(funct3, addr[1:0]) : 4'd0;
                        mem_wdata <= req_we ? store_data(funct3, wdata) : 32'd0;
                        lat_f3    <= funct3;
                        lat_lo    <= addr[1:0];
                        cnt       <= 32'd0;
                        err       <= 1'b0;
                        rdata     <= 32'd0;
                    end
                end
                REQ: if (mem_gnt) begin
                    mem_req <= 1'b0;
                    if (mem_we) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end else if (timeout_hit) begin
                    mem_req <= 1'b0;
                    state   <= DONE;
                    done    <= 1'b1;
                    err     <= 1'b1;
                    rdata   <= 32'd0;
                end
                WAIT: if (mem_rvalid) begin
                    rdata <= ext_rdata;
                    state <= DONE;
                    done  <= 1'b1;
                end else if (timeout_hit) begin
                    state <= DONE;
                    done  <= 1'b1;
                    err   <= 1'b1;
                    rdata <= 32'd0;
                end
                DONE: begin
                    state <= IDLE;
                    err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a 4-cycle timeout; expected values are hand-computed.
module tb_lsu_mem_stage;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        stall, done, err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int n_checks = 0;
    int n_err = 0;

    lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
        .err(err), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        #1;
    endtask

    task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] exp_addr,
                             input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        issue(1'b1, f3, a, wd);
        chk({tag, "_c1_stall"}, 32'(stall), 32'd1);
        chk({tag, "_c1_req"}, 32'(mem_req), 32'd0);
        mem_gnt = 1'b1;
        tick();
        chk({tag, "_c2_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_c2_stall"}, 32'(stall), 32'd1);
        chk({tag, "_we"}, 32'(mem_we), 32'd1);
        chk({tag, "_addr"}, mem_addr, exp_addr);
        chk({tag, "_strb"}, 32'(mem_wstrb), 32'(exp_strb));
        chk({tag, "_wdata"}, mem_wdata, exp_wdata);
        tick();
        mem_gnt = 1'b0;
        chk({tag, "_c3_done"}, 32'(done), 32'd1);
        chk({tag, "_c3_err"}, 32'(err), 32'd0);
        chk({tag, "_c3_stall"}, 32'(stall), 32'd0);
        chk({tag, "_c3_req"}, 32'(mem_req), 32'd0);
        req_valid = 1'b0;
        tick();
    endtask

    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] exp_addr, input logic [31:0] word,
                            input logic [31:0] exp);
        issue(1'b0, f3, a, 32'd0);
        mem_gnt = 1'b1;
        tick();
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_strb"}, 32'(mem_wstrb), 32'd0);
        chk({tag, "_addr"}, mem_addr, exp_addr);
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        #1;
        chk({tag, "_wait_stall"}, 32'(stall), 32'd1);
        chk({tag, "_wait_req"}, 32'(mem_req), 32'd0);
        tick();
        mem_rvalid = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_rdata"}, rdata, exp);
        req_valid = 1'b0;
        tick();
    endtask

    task automatic run_err(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] a);
        issue(we, f3, a, 32'h1234_5678);
        chk({tag, "_c1_req"}, 32'(mem_req), 32'd0);
        tick();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'd1);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_req"}, 32'(mem_req), 32'd0);
        req_valid = 1'b0;
        tick();
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
    endtask

    initial begin
        #3;
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        run_store("sw", F3_W, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
        run_store("sb", F3_B, 32'h0000_0103, 32'h0000_00A5, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5);
        run_store("sh", F3_H, 32'h0000_0102, 32'h0000_BEEF, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF);

        run_load("lb",  F3_B,  32'h0000_0202, 32'h0000_0200, 32'h1280_FF34, 32'hFFFF_FF80);
        run_err("lw_mis", 1'b0, F3_W, 32'h0000_0106);
        run_load("lbu", F3_BU, 32'h0000_0202, 32'h0000_0200, 32'h1280_FF34, 32'h0000_0080);
        run_err("sbu_ill", 1'b1, F3_BU, 32'h0000_0100);
        run_load("lh",  F3_H,  32'h0000_0200, 32'h0000_0200, 32'h1280_FF34, 32'hFFFF_FF34);
        run_err("sh_mis", 1'b1, F3_H, 32'h0000_0101);
        run_load("lhu", F3_HU, 32'h0000_0202, 32'h0000_0200, 32'h1280_FF34, 32'h0000_1280);

        // timeout with no grant: four request cycles then an error completion
        issue(1'b0, F3_W, 32'h0000_0400, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_req_held", 32'(mem_req), 32'd1);
            chk("to_no_done", 32'(done), 32'd0);
        end
        tick();
        chk("to_done", 32'(done), 32'd1);
        chk("to_err", 32'(err), 32'd1);
        chk("to_rdata", rdata, 32'd0);
        chk("to_req_drop", 32'(mem_req), 32'd0);
        req_valid = 1'b0;
        tick();

        // grant arrives on the final allowed cycle: handshake wins
        issue(1'b1, F3_W, 32'h0000_0404, 32'h0BAD_F00D);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("tg_req_held", 32'(mem_req), 32'd1);
        end
        tick();
        chk("tg_req_c4", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("tg_done", 32'(done), 32'd1);
        chk("tg_err", 32'(err), 32'd0);
        req_valid = 1'b0;
        tick();

        // async reset while a load waits for data
        issue(1'b0, F3_W, 32'h0000_0300, 32'd0);
        mem_gnt = 1'b1;
        tick();
        tick();
        mem_gnt = 1'b0;
        chk("rw_in_wait", 32'(dut.state), 32'(WAIT));
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rw_state", 32'(dut.state), 32'(IDLE));
        chk("rw_req", 32'(mem_req), 32'd0);
        chk("rw_done", 32'(done), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        issue(1'b0, F3_W, 32'h0000_0304, 32'd0);
        chk("rn_idle_req", 32'(mem_req), 32'd0);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBADB_AD00;
        tick();
        chk("rn_stale_req", 32'(mem_req), 32'd1);
        chk("rn_stale_done", 32'(done), 32'd0);
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1122_3344;
        tick();
        mem_rvalid = 1'b0;
        chk("rn_done", 32'(done), 32'd1);
        chk("rn_err", 32'(err), 32'd0);
        chk("rn_rdata", rdata, 32'h1122_3344);
        req_valid = 1'b0;
        tick();
        chk("rn_idle", 32'(dut.state), 32'(IDLE));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit downstream of the ALU in the RV32I single-cycle core. Consumes the ALU result as the effective address and rs2 as store data.
- Drives a word-wide memory bus with req/gnt/rvalid handshake, then returns sign- or zero-extended load data to writeback.
- Stalls the core while a bus transaction is outstanding; flags misaligned or illegal accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles spent in REQ+WAIT before forced abort; 0 disables the timeout.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  current instruction is a load or store
- req_we  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width/sign field
- addr  in  32  effective address (ALU result)
- wdata  in  32  store data (rs2)
- stall  out  1  freeze PC and regfile write; equals req_valid & ~done
- done  out  1  one-cycle pulse; access complete, or aborted with err
- err  out  1  valid with done; misaligned, illegal funct3, or timeout
- rdata  out  32  extended load data, valid with done
- mem_req  out  1  bus request, held until mem_gnt
- mem_we  out  1  bus write enable
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- mem_wstrb  out  4  byte-lane strobes
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  bus accepted request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data word

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Async reset forces IDLE from any state, including mid-transaction; mem_req drops immediately.
- Reset values: all registered outputs 0, rdata 0.
- IDLE with req_valid=1:
  - Legal loads: funct3 000/001/010/100/101. Legal stores: funct3 000/001/010.
  - Alignment: half requires addr[0]=0; word requires addr[1:0]=00.
  - Illegal or misaligned: go to DONE with err=1 and rdata=0; no bus activity.
  - Otherwise latch addr, wdata, funct3 and req_we, then go to REQ.
- REQ: mem_req=1, bus fields driven from the latched values.
  - On mem_gnt: a store goes to DONE; a load goes to WAIT.
- WAIT: on mem_rvalid, capture the extended mem_rdata into rdata, then go to DONE. mem_rvalid in any other state is ignored; the earliest legal rvalid is the cycle after gnt.
- DONE: done=1 for exactly one cycle, then return to IDLE. req_valid is ignored in DONE because the core advances on this edge. Back-to-back accesses are allowed: a new request is sampled on the first IDLE cycle.
- Minimum latency with gnt and rvalid both immediate:
  - Store: 3 cycles of req_valid (IDLE, REQ, DONE), stall=1 for the first 2.
  - Load: 4 cycles.
- Store lanes:
  - SB: strobe 0001<<addr[1:0], data {4{wdata[7:0]}}.
  - SH: strobe 0011<<{addr[1],1'b0}, data {2{wdata[15:0]}}.
  - SW: strobe 1111, data wdata.
  - mem_wstrb is 0 for loads.
- Load extract: select the byte or halfword lane from addr[1:0]. funct3[2]=0 sign-extends; 1 zero-extends.
- Timeout: a counter clears on IDLE→REQ and increments in REQ and WAIT.
  - Reaching TIMEOUT_CYCLES goes to DONE with err=1 and rdata=0; mem_req drops.
  - If gnt or rvalid arrives in the same cycle the limit is reached, the handshake wins.
- stall is combinational, so it is high in the same cycle req_valid rises.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU
  - state enum
  - strobe/size helper functions
- One combinational sub-module, lsu_load_extend (inputs funct3, addr[1:0], mem_rdata; output rdata), reused by future cache logic.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt immediate → one mem_req cycle, mem_addr=0x100, wstrb=1111, done on cycle 3, stall high for 2 cycles.
- SB addr=0x103, wdata=0x000000A5 → wstrb=1000, wdata=0xA5A5A5A5, mem_addr=0x100.
- LB addr=0x202, mem_rdata=0x1280FF34 → rdata=0xFFFFFF80. LBU at the same address → 0x00000080. LHU addr=0x202 → 0x00001280.
- LW addr=0x106 → err=1 and done on the next cycle, mem_req never asserted. Store with funct3=100 → err=1.
- TIMEOUT_CYCLES=4, gnt never asserted → mem_req high 4 cycles, then done=1, err=1, rdata=0. Repeat with gnt in cycle 4 → no err.
- Assert rst_n=0 during WAIT → mem_req=0 and state IDLE immediately. After release, a new LW completes normally and a late stale rvalid is ignored.
